// File: rtl/st_pkg.sv
// Shared definitions for the stencil command channel: command bit positions,
// terminator word, command word width and the sequencer state encoding.
package st_pkg;

    localparam int ST_W_CMD = 32;

    localparam int ST_INIT_SUM = 2;
    localparam int ST_CALC_SUM = 1;
    localparam int ST_HOT_SPOT = 0;

    localparam logic [7:0] ST_CMD_TERM = 8'hff;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SIZE,
        ST_SIZE_GAP,
        ST_CMD,
        ST_CMD_GAP,
        ST_RWAIT,
        ST_RGAP,
        ST_RCAP,
        ST_TERM,
        ST_TERM_GAP
    } st_state_e;

endpackage

// File: rtl/st_cmd_pack.sv
// Combinational builder for one row-pass command word:
// bits [2:0] = {init_sum, calc_sum, hot_spot}, all upper bits zero.
module st_cmd_pack
    import st_pkg::*;
#(
    parameter int W_D   = ST_W_CMD,
    parameter int W_ROW = 16
) (
    input  logic [W_ROW-1:0] row_i,
    input  logic             calc_only_i,
    input  logic             hot_en_i,
    input  logic [W_ROW-1:0] hot_row_i,
    output logic [W_D-1:0]   cmd_o
);

    always_comb begin
        cmd_o              = '0;
        cmd_o[ST_INIT_SUM] = (row_i == '0);
        cmd_o[ST_CALC_SUM] = calc_only_i;
        cmd_o[ST_HOT_SPOT] = hot_en_i && (row_i == hot_row_i);
    end

endmodule

// File: rtl/st_cmd_sequencer.sv
// Host-side command sequencer for the stencil kernel: mesh size, one command per
// row with reply capture, then terminator. ST_CMD_SEQUENCER_TIMEOUT_EN adds a reply timeout.
module st_cmd_sequencer
    import st_pkg::*;
#(
    parameter int W_D   = ST_W_CMD,
    parameter int W_ROW = 16
`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [W_D-1:0]   cfg_mesh_size,
    input  logic [W_ROW-1:0] cfg_num_rows,
    input  logic             cfg_calc_only,
    input  logic             cfg_hot_en,
    input  logic [W_ROW-1:0] cfg_hot_row,
    output logic [W_D-1:0]   tx_d,
    output logic             tx_enq,
    input  logic             tx_full,
    input  logic [W_D-1:0]   rx_q,
    output logic             rx_deq,
    input  logic             rx_empty,
    output logic             busy,
    output logic             done,
    output logic [W_D-1:0]   last_sum,
    output logic [W_ROW-1:0] reply_count,
    output logic             err
);

    st_state_e        state_q, state_d;
    logic [W_ROW-1:0] row_q, row_d, rows_q, rows_d, hot_row_q, hot_row_d;
    logic [W_D-1:0]   mesh_q, mesh_d, tx_d_q, tx_d_d, last_sum_q, last_sum_d;
    logic [W_ROW-1:0] reply_count_q, reply_count_d;
    logic             calc_q, calc_d, hot_en_q, hot_en_d;
    logic             tx_enq_q, tx_enq_d, rx_deq_q, rx_deq_d;
    logic             done_q, done_d, busy_q, busy_d;
    logic [W_D-1:0]   cmd_word;
    logic [W_ROW-1:0] row_inc;

`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    assign row_inc = row_q + 1'b1;

    st_cmd_pack #(.W_D(W_D), .W_ROW(W_ROW)) u_pack (
        .row_i       (row_q),
        .calc_only_i (calc_q),
        .hot_en_i    (hot_en_q),
        .hot_row_i   (hot_row_q),
        .cmd_o       (cmd_word)
    );

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        rows_d        = rows_q;
        hot_row_d     = hot_row_q;
        mesh_d        = mesh_q;
        calc_d        = calc_q;
        hot_en_d      = hot_en_q;
        tx_d_d        = tx_d_q;
        last_sum_d    = last_sum_q;
        reply_count_d = reply_count_q;
        tx_enq_d      = 1'b0;
        rx_deq_d      = 1'b0;
        done_d        = 1'b0;
`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
        tcnt_d        = tcnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mesh_d        = cfg_mesh_size;
                    rows_d        = cfg_num_rows;
                    calc_d        = cfg_calc_only;
                    hot_en_d      = cfg_hot_en;
                    hot_row_d     = cfg_hot_row;
                    row_d         = '0;
                    reply_count_d = '0;
                    last_sum_d    = '0;
`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
                    err_d         = 1'b0;
`endif
                    state_d       = ST_SIZE;
                end
            end
            ST_SIZE: begin
                tx_d_d = mesh_q;
                if (!tx_full) begin
                    tx_enq_d = 1'b1;
                    state_d  = ST_SIZE_GAP;
                end
            end
            // A zero-row run still sends the mesh size, then goes straight to the terminator.
            ST_SIZE_GAP: state_d = (rows_q == '0) ? ST_TERM : ST_CMD;
            ST_CMD: begin
                tx_d_d = cmd_word;
                if (!tx_full) begin
                    tx_enq_d = 1'b1;
                    state_d  = ST_CMD_GAP;
                end
            end
            ST_CMD_GAP: state_d = ST_RWAIT;
            ST_RWAIT: begin
                if (!rx_empty) begin
                    rx_deq_d = 1'b1;
                    state_d  = ST_RGAP;
                end
`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_TERM;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            ST_RGAP: state_d = ST_RCAP;
            ST_RCAP: begin
                last_sum_d    = rx_q;
                reply_count_d = reply_count_q + 1'b1;
                row_d         = row_inc;
                state_d       = (row_inc == rows_q) ? ST_TERM : ST_CMD;
            end
            // done is registered alongside the terminator strobe.
            ST_TERM: begin
                tx_d_d = W_D'(ST_CMD_TERM);
                if (!tx_full) begin
                    tx_enq_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_TERM_GAP;
                end
            end
            ST_TERM_GAP: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
        if (state_d != ST_RWAIT) tcnt_d = '0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            rows_q        <= '0;
            hot_row_q     <= '0;
            mesh_q        <= '0;
            calc_q        <= 1'b0;
            hot_en_q      <= 1'b0;
            tx_d_q        <= '0;
            last_sum_q    <= '0;
            reply_count_q <= '0;
            tx_enq_q      <= 1'b0;
            rx_deq_q      <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            rows_q        <= rows_d;
            hot_row_q     <= hot_row_d;
            mesh_q        <= mesh_d;
            calc_q        <= calc_d;
            hot_en_q      <= hot_en_d;
            tx_d_q        <= tx_d_d;
            last_sum_q    <= last_sum_d;
            reply_count_q <= reply_count_d;
            tx_enq_q      <= tx_enq_d;
            rx_deq_q      <= rx_deq_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign tx_d        = tx_d_q;
    assign tx_enq      = tx_enq_q;
    assign rx_deq      = rx_deq_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign last_sum    = last_sum_q;
    assign reply_count = reply_count_q;

endmodule

// File: tb/tb_st_cmd_sequencer.sv
// Directed bench for st_cmd_sequencer with a small FIFO/kernel stand-in that
// answers each command word with the next value from a reply table.
module tb_st_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_mesh_size = '0;
    logic [15:0] cfg_num_rows = '0;
    logic        cfg_calc_only = 1'b0;
    logic        cfg_hot_en = 1'b0;
    logic [15:0] cfg_hot_row = '0;
    logic [31:0] tx_d;
    logic        tx_enq;
    logic        tx_full = 1'b0;
    logic [31:0] rx_q = '0;
    logic        rx_deq;
    logic        rx_empty = 1'b1;
    logic        busy, done, err;
    logic [31:0] last_sum;
    logic [15:0] reply_count;

    always #5 CLK = ~CLK;

    st_cmd_sequencer #(
        .W_D   (32),
        .W_ROW (16)
`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .cfg_mesh_size (cfg_mesh_size),
        .cfg_num_rows  (cfg_num_rows),
        .cfg_calc_only (cfg_calc_only),
        .cfg_hot_en    (cfg_hot_en),
        .cfg_hot_row   (cfg_hot_row),
        .tx_d          (tx_d),
        .tx_enq        (tx_enq),
        .tx_full       (tx_full),
        .rx_q          (rx_q),
        .rx_deq        (rx_deq),
        .rx_empty      (rx_empty),
        .busy          (busy),
        .done          (done),
        .last_sum      (last_sum),
        .reply_count   (reply_count),
        .err           (err)
    );

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = -1;
    int          deq_cnt = 0, done_cnt = 0, full_viol = 0, both_viol = 0;
    bit          reply_hold = 1'b0;
    logic        full_at_edge = 1'b0;
    logic [31:0] tx_log[$];
    int          tx_cyc[$];
    logic [31:0] rx_fifo[$];
    logic [31:0] reply_tab[$];
    logic [31:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) full_at_edge <= tx_full;

    // Reply FIFO with one cycle of read latency; reset together with the sequencer.
    always @(posedge CLK) begin
        if (RST) begin
            rx_fifo.delete();
            rx_q <= '0;
        end else if (rx_deq && rx_fifo.size() > 0) begin
            rx_q <= rx_fifo.pop_front();
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (tx_enq) begin
                if (tx_log.size() > 0 && tx_d != 32'hff && !reply_hold && reply_tab.size() > 0)
                    rx_fifo.push_back(reply_tab.pop_front());
                tx_log.push_back(tx_d);
                tx_cyc.push_back(cyc);
                if (full_at_edge) full_viol++;
            end
            if (rx_deq) begin
                deq_cnt++;
                if (tx_enq) both_viol++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        rx_empty = (rx_fifo.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_tx(input string tag);
        logic [31:0] obs;
        chk({tag, "_ntx"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < tx_log.size()) ? tx_log[i] : 32'hdeadbeef;
            chk($sformatf("%s_tx%0d", tag, i), obs, exp_q[i]);
        end
        $display("[%0t] %s: %0d words enqueued", $time, tag, tx_log.size());
    endtask

    task automatic clr();
        tx_log.delete();
        tx_cyc.delete();
        reply_tab.delete();
        deq_cnt = 0;
        done_cnt = 0;
        full_viol = 0;
        both_viol = 0;
        done_cyc = -1;
    endtask

    task automatic do_start(input logic [31:0] mesh, input logic [15:0] rows, input logic calc,
                            input logic hot_en, input logic [15:0] hot_row);
        @(negedge CLK);
        cfg_mesh_size = mesh;
        cfg_num_rows  = rows;
        cfg_calc_only = calc;
        cfg_hot_en    = hot_en;
        cfg_hot_row   = hot_row;
        start         = 1'b1;
        start_cyc     = cyc;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_d"}, tx_d, 32'd0);
        chk({tag, "_tx_enq"}, {31'b0, tx_enq}, 32'd0);
        chk({tag, "_rx_deq"}, {31'b0, rx_deq}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_last_sum"}, last_sum, 32'd0);
        chk({tag, "_reply_count"}, {16'b0, reply_count}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        int n;
        int rel_cyc;

        repeat (3) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b0;

        // Basic run: 3 rows, replies 10/20/30
        clr();
        reply_tab = {32'd10, 32'd20, 32'd30};
        do_start(32'd16, 16'd3, 1'b0, 1'b0, 16'd0);
        wait_done("basic", 200);
        exp_q = {32'd16, 32'h4, 32'h0, 32'h0, 32'hff};
        chk_tx("basic");
        chk("basic_first_enq_lat", (tx_cyc.size() > 0) ? tx_cyc[0] - start_cyc : -1, 32'd2);
        chk("basic_last_sum", last_sum, 32'd30);
        chk("basic_reply_count", {16'b0, reply_count}, 32'd3);
        chk("basic_done_cnt", done_cnt, 32'd1);
        chk("basic_deq_cnt", deq_cnt, 32'd3);
        chk("basic_busy", {31'b0, busy}, 32'd0);
        chk("basic_err", {31'b0, err}, 32'd0);
        chk("basic_both_strobes", both_viol, 32'd0);

        // Hot spot on row 1
        clr();
        reply_tab = {32'd1, 32'd2, 32'd3};
        do_start(32'd16, 16'd3, 1'b0, 1'b1, 16'd1);
        wait_done("hot", 200);
        exp_q = {32'd16, 32'h4, 32'h1, 32'h0, 32'hff};
        chk_tx("hot");
        chk("hot_last_sum", last_sum, 32'd3);

        // calc_only with hot spot on row 0
        clr();
        reply_tab = {32'h55, 32'h66};
        do_start(32'd7, 16'd2, 1'b1, 1'b1, 16'd0);
        wait_done("calc", 200);
        exp_q = {32'd7, 32'h7, 32'h2, 32'hff};
        chk_tx("calc");
        chk("calc_last_sum", last_sum, 32'h66);
        chk("calc_reply_count", {16'b0, reply_count}, 32'd2);

        // Zero rows: size then terminator, done 4 cycles after start
        clr();
        do_start(32'd16, 16'd0, 1'b0, 1'b0, 16'd0);
        wait_done("zero", 50);
        exp_q = {32'd16, 32'hff};
        chk_tx("zero");
        chk("zero_deq_cnt", deq_cnt, 32'd0);
        chk("zero_done_lat", done_cyc - start_cyc, 32'd4);
        chk("zero_last_sum_cleared", last_sum, 32'd0);
        chk("zero_reply_count", {16'b0, reply_count}, 32'd0);

        // Back-pressure on the second command
        clr();
        reply_tab = {32'd5, 32'd6, 32'd7};
        do_start(32'd9, 16'd3, 1'b0, 1'b0, 16'd0);
        n = 0;
        while (reply_count != 16'd1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_first_reply", {16'b0, reply_count}, 32'd1);
        tx_full = 1'b1;
        repeat (20) @(negedge CLK);
        chk("bp_hold_ntx", tx_log.size(), 32'd2);
        tx_full = 1'b0;
        rel_cyc = cyc;
        wait_done("bp", 200);
        exp_q = {32'd9, 32'h4, 32'h0, 32'h0, 32'hff};
        chk_tx("bp");
        chk("bp_release_lat", (tx_cyc.size() > 2) ? tx_cyc[2] - rel_cyc : -1, 32'd1);
        chk("bp_full_viol", full_viol, 32'd0);
        chk("bp_last_sum", last_sum, 32'd7);

        // Reset while waiting for a reply
        clr();
        reply_hold = 1'b1;
        do_start(32'd16, 16'd3, 1'b0, 1'b0, 16'd0);
        repeat (6) @(negedge CLK);
        chk("rst_busy_before", {31'b0, busy}, 32'd1);
        chk("rst_ntx_before", tx_log.size(), 32'd2);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_outputs("midrst");
        RST = 1'b0;
        reply_hold = 1'b0;
        clr();
        reply_tab = {32'd10, 32'd20, 32'd30};
        do_start(32'd16, 16'd3, 1'b0, 1'b0, 16'd0);
        wait_done("after_rst", 200);
        exp_q = {32'd16, 32'h4, 32'h0, 32'h0, 32'hff};
        chk_tx("after_rst");
        chk("after_rst_last_sum", last_sum, 32'd30);
        chk("after_rst_done_cnt", done_cnt, 32'd1);

`ifdef ST_CMD_SEQUENCER_TIMEOUT_EN
        // No reply ever arrives: timeout ends the run with the terminator
        clr();
        reply_hold = 1'b1;
        do_start(32'd16, 16'd2, 1'b0, 1'b0, 16'd0);
        wait_done("tmo", 100);
        exp_q = {32'd16, 32'h4, 32'hff};
        chk_tx("tmo");
        chk("tmo_err", {31'b0, err}, 32'd1);
        chk("tmo_reply_count", {16'b0, reply_count}, 32'd0);
        chk("tmo_done_cnt", done_cnt, 32'd1);
        chk("tmo_deq_cnt", deq_cnt, 32'd0);
        reply_hold = 1'b0;
        clr();
        do_start(32'd16, 16'd0, 1'b0, 1'b0, 16'd0);
        chk("tmo_err_cleared", {31'b0, err}, 32'd0);
        wait_done("tmo_next", 50);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
